// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state, op-code and sizing definitions for the HI/LO sequencer
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Same encoding is decoded by mult_div on its control input
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam int CYCLES_DEFAULT = 32;

  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - mult_div iteration sequencer with architectural HI/LO registers
import hilo_pkg::*;

module hilo_sequencer #(
  parameter int CYCLES = CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        op_start_i,
  input  logic [1:0]  op_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] md_high_i,
  input  logic [31:0] md_low_i,
  input  logic        md_div_zero_i,
  output logic [1:0]  md_control_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_exc_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DZCHK = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      op_q    <= MD_NONE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi_i) hi_d = wr_data_i;
        if (mtlo_i) lo_d = wr_data_i;
        if (op_start_i && is_valid_op(op_i)) begin
          state_d = RUN;
          op_d    = op_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // mult_div flags a zero divisor after its first iteration; abort without touching HI/LO
        if (op_q == MD_DIV && cnt_q == CNT_DZCHK && md_div_zero_i) begin
          dz_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        if (op_q == MD_DIV) begin
          lo_d = md_high_i;
          hi_d = md_low_i;
        end else begin
          hi_d = md_high_i;
          lo_d = md_low_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    md_control_o = MD_NONE;
    busy_o       = 1'b0;
    if (state_q != IDLE) begin
      md_control_o = op_q;
      busy_o       = 1'b1;
    end
  end

  assign done_o         = done_q;
  assign div_zero_exc_o = dz_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

endmodule
